// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI-Lite register file.
//   axi_resp_e  : AXI response codes carried on b_resp / r_resp
//   wr_state_e  : write engine states
//   rd_state_e  : read engine states
//   resp_for()  : maps a decode-error flag onto OKAY / SLVERR
package axi_lite_pkg;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_RESP = 1'b1
   } wr_state_e;

   typedef enum logic {
      RD_IDLE = 1'b0,
      RD_RESP = 1'b1
   } rd_state_e;

   function automatic axi_resp_e resp_for(input logic err);
      return err ? SLVERR : OKAY;
   endfunction

endpackage

// File: rtl/axi_lite_regfile_if.sv
// AXI-Lite bus bundle (AW, W, B, AR, R channels).
//   master : initiator view (drives addresses, data, valids, b_ready/r_ready)
//   slave  : responder view (drives readies, responses, read data)
interface axi_lite_regfile_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   aw_addr;
   logic                    aw_valid;
   logic                    aw_ready;
   logic [DATA_WIDTH-1:0]   w_data;
   logic [DATA_WIDTH/8-1:0] w_strb;
   logic                    w_valid;
   logic                    w_ready;
   logic [1:0]              b_resp;
   logic                    b_valid;
   logic                    b_ready;
   logic [ADDR_WIDTH-1:0]   ar_addr;
   logic                    ar_valid;
   logic                    ar_ready;
   logic [DATA_WIDTH-1:0]   r_data;
   logic [1:0]              r_resp;
   logic                    r_valid;
   logic                    r_ready;

   modport master (
      output aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
             ar_addr, ar_valid, r_ready,
      input  aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
   );

   modport slave (
      input  aw_addr, aw_valid, w_data, w_strb, w_valid, b_ready,
             ar_addr, ar_valid, r_ready,
      output aw_ready, w_ready, b_resp, b_valid, ar_ready, r_data, r_resp, r_valid
   );
endinterface

// File: rtl/axi_lite_regfile_wr.sv
// Write engine of the AXI-Lite register file.
// Captures AW and W independently, then issues a one-cycle commit strobe
// (register index, data, strobes) and holds the B response until accepted.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   aw_* / w_* / b_*              AXI-Lite write channels
//   commit                        one-cycle write strobe to storage
//   commit_idx/data/strb          register index (address >> byte shift), data, lanes
//   commit_err                    decode error for commit_idx, latched into b_resp
module axi_lite_regfile_wr
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   aw_addr,
   input  logic                    aw_valid,
   output logic                    aw_ready,
   input  logic [DATA_WIDTH-1:0]   w_data,
   input  logic [DATA_WIDTH/8-1:0] w_strb,
   input  logic                    w_valid,
   output logic                    w_ready,
   output logic [1:0]              b_resp,
   output logic                    b_valid,
   input  logic                    b_ready,
   output logic                    commit,
   output logic [ADDR_WIDTH-1:0]   commit_idx,
   output logic [DATA_WIDTH-1:0]   commit_data,
   output logic [DATA_WIDTH/8-1:0] commit_strb,
   input  logic                    commit_err
);
   // state   | meaning
   // WR_IDLE | collecting AW and W; commit once both are held
   // WR_RESP | B response valid, waiting for b_ready

   localparam int SHIFT = $clog2(DATA_WIDTH/8);

   wr_state_e               state_q, state_d;
   logic                    aw_held_q, w_held_q;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic [DATA_WIDTH/8-1:0] strb_q;
   axi_resp_e               resp_q;

   // Readies/valids are gated by rst so they read 0 during reset and are
   // back to 1 in the first cycle after rst falls.
   always_comb begin
      state_d  = state_q;
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
      commit   = 1'b0;
      case (state_q)
         WR_IDLE: begin
            aw_ready = !aw_held_q && !rst;
            w_ready  = !w_held_q && !rst;
            if (aw_held_q && w_held_q) begin
               commit  = !rst;
               state_d = WR_RESP;
            end
         end
         WR_RESP: begin
            b_valid = !rst;
            if (b_ready) state_d = WR_IDLE;
         end
         default: state_d = WR_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= WR_IDLE;
         aw_held_q <= 1'b0;
         w_held_q  <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         strb_q    <= '0;
         resp_q    <= OKAY;
      end else begin
         state_q <= state_d;
         if (aw_valid && aw_ready) begin
            aw_held_q <= 1'b1;
            addr_q    <= aw_addr;
         end
         if (w_valid && w_ready) begin
            w_held_q <= 1'b1;
            data_q   <= w_data;
            strb_q   <= w_strb;
         end
         if (commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            resp_q    <= resp_for(commit_err);
         end
      end
   end

   assign b_resp      = resp_q;
   assign commit_idx  = addr_q >> SHIFT;
   assign commit_data = data_q;
   assign commit_strb = strb_q;

endmodule

// File: rtl/axi_lite_regfile.sv
// AXI-Lite register file: NUM_REGS read/write registers, register i at byte
// offset i*(DATA_WIDTH/8), contents exported flat on regs_q.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        axi_lite_regfile_if.slave (AW, W, B, AR, R channels)
//   regs_q     register i at [i*DATA_WIDTH +: DATA_WIDTH]
// Build option:
//   AXIL_REGFILE_SLVERR_EN  out-of-range accesses answer SLVERR; otherwise
//                           they answer OKAY (writes dropped, reads return 0).
module axi_lite_regfile
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   axi_lite_regfile_if.slave            bus,
   output logic [NUM_REGS*DATA_WIDTH-1:0] regs_q
);
   // state   | meaning
   // RD_IDLE | accepting AR
   // RD_RESP | R data valid, waiting for r_ready

   localparam int SHIFT = $clog2(DATA_WIDTH/8);
   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int STRB_W = DATA_WIDTH/8;
   localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];

   logic                  wr_commit;
   logic [ADDR_WIDTH-1:0] wr_idx;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [STRB_W-1:0]     wr_strb;
   logic                  wr_in_range, wr_err;

   logic [ADDR_WIDTH-1:0] rd_idx;
   logic                  rd_in_range, rd_err;
   rd_state_e             rd_q, rd_d;
   logic [DATA_WIDTH-1:0] r_data_q;
   axi_resp_e             r_resp_q;

   assign wr_in_range = wr_idx < NUM_REGS_A;
   assign rd_idx      = bus.ar_addr >> SHIFT;
   assign rd_in_range = rd_idx < NUM_REGS_A;

`ifdef AXIL_REGFILE_SLVERR_EN
   assign wr_err = !wr_in_range;
   assign rd_err = !rd_in_range;
`else
   assign wr_err = 1'b0;
   assign rd_err = 1'b0;
`endif

   axi_lite_regfile_wr #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_wr (
      .clk         (clk),
      .rst         (rst),
      .aw_addr     (bus.aw_addr),
      .aw_valid    (bus.aw_valid),
      .aw_ready    (bus.aw_ready),
      .w_data      (bus.w_data),
      .w_strb      (bus.w_strb),
      .w_valid     (bus.w_valid),
      .w_ready     (bus.w_ready),
      .b_resp      (bus.b_resp),
      .b_valid     (bus.b_valid),
      .b_ready     (bus.b_ready),
      .commit      (wr_commit),
      .commit_idx  (wr_idx),
      .commit_data (wr_data),
      .commit_strb (wr_strb),
      .commit_err  (wr_err)
   );

   // Storage. A read captured on the commit edge sees the pre-write value
   // because both use non-blocking updates of the same array.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_commit && wr_in_range) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == ADDR_WIDTH'(i)) begin
               for (int k = 0; k < STRB_W; k++) begin
                  if (wr_strb[k]) regs[i][k*8 +: 8] <= wr_data[k*8 +: 8];
               end
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
      assign regs_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
   end

   always_comb begin
      rd_d         = rd_q;
      bus.ar_ready = 1'b0;
      bus.r_valid  = 1'b0;
      case (rd_q)
         RD_IDLE: begin
            bus.ar_ready = !rst;
            if (bus.ar_valid) rd_d = RD_RESP;
         end
         RD_RESP: begin
            bus.r_valid = !rst;
            if (bus.r_ready) rd_d = RD_IDLE;
         end
         default: rd_d = RD_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_q     <= RD_IDLE;
         r_data_q <= '0;
         r_resp_q <= OKAY;
      end else begin
         rd_q <= rd_d;
         if (bus.ar_valid && bus.ar_ready) begin
            r_data_q <= rd_in_range ? regs[rd_idx[IDX_W-1:0]] : '0;
            r_resp_q <= resp_for(rd_err);
         end
      end
   end

   assign bus.r_data = r_data_q;
   assign bus.r_resp = r_resp_q;

endmodule
